// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the LED-catch game
//
// Purpose: FSM state encoding for object_spawner, 8x8 matrix geometry,
//          LFSR feedback mask, default seed and a one-step LFSR helper.
// Ports:   none (package)
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_FALL   = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam int COLS   = 8;
    localparam int ROWS   = 8;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Taps 8,6,5,4 (1-based) -> state bits 7,5,4,3; maximal length, never 0.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR with enable
//
// Purpose: pseudo-random source for object column/colour (and later the
//          player-colour randomiser).
// Ports:   clock   - system clock
//          resetn  - asynchronous active-low reset, loads SEED
//          enable  - advance one step on this edge
//          state   - current 8-bit LFSR value
module lfsr8
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    output logic [7:0] state
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= SEED;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/object_spawner.sv
// rtl/object_spawner.sv - paces falling objects and keeps score/lives/level
//
// Purpose: launches one object at a time into dropping_object with a random
//          column and one-hot colour, waits for its landing result, tracks
//          score, lives and level, and shortens the inter-object gap per level.
// Ports:   clock, resetn           - clock, asynchronous active-low reset
//          start                   - pulse, starts a game from IDLE or OVER
//          pause                   - freezes gap and timeout counters
//          res_valid, res_hit      - landing result for the current object
//          drop_go                 - one-cycle launch pulse
//          drop_addr, drop_data    - start address {col,3'b000}, colour
//          drop_speed              - constant 1
//          score, lives, level     - game status
//          game_over, busy         - OVER state, LAUNCH/FALL states
module object_spawner
    import game_pkg::*;
#(
    parameter logic [15:0] GAP_BASE   = 16'd1000,
    parameter logic [15:0] GAP_STEP   = 16'd100,
    parameter logic [15:0] GAP_MIN    = 16'd50,
    parameter logic [7:0]  LEVEL_STEP = 8'd8,
    parameter logic [1:0]  LIVES      = 2'd3,
    parameter logic [15:0] TIMEOUT    = 16'd4096,
    parameter logic [7:0]  SEED       = DEFAULT_SEED
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    input  logic              res_valid,
    input  logic              res_hit,
    output logic              drop_go,
    output logic [ADDR_W-1:0] drop_addr,
    output logic [DATA_W-1:0] drop_data,
    output logic [5:0]        drop_speed,
    output logic [7:0]        score,
    output logic [1:0]        lives,
    output logic [2:0]        level,
    output logic              game_over,
    output logic              busy
);

    state_t state, state_nx;

    logic [15:0]       gap_cnt, gap_cnt_nx;
    logic [15:0]       to_cnt, to_cnt_nx;
    logic [7:0]        score_nx;
    logic [1:0]        lives_nx;
    logic [2:0]        level_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx;
    logic [7:0]        lfsr_q;
    logic              lfsr_unused;
    logic              done;
    logic              hit;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .enable (1'b1),
        .state  (lfsr_q)
    );

    // Top two LFSR bits do not feed column or colour selection.
    assign lfsr_unused = ^lfsr_q[7:6];

    // Gap for a given level, clamped at GAP_MIN; an oversized reduction
    // (subtraction underflow) also yields GAP_MIN.
    function automatic logic [15:0] gap_for(input logic [2:0] lvl);
        logic [31:0] dec;
        logic [15:0] diff;
        dec = 32'(lvl) * 32'(GAP_STEP);
        if (dec >= {16'd0, GAP_BASE}) begin
            return GAP_MIN;
        end
        diff = GAP_BASE - dec[15:0];
        return (diff < GAP_MIN) ? GAP_MIN : diff;
    endfunction

    function automatic logic [2:0] level_of(input logic [7:0] s);
        logic [7:0] q;
        q = s / LEVEL_STEP;
        return (q > 8'd7) ? 3'd7 : q[2:0];
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            score     <= '0;
            lives     <= LIVES;
            level     <= '0;
            drop_addr <= '0;
            drop_data <= 8'h01;
        end else begin
            state     <= state_nx;
            gap_cnt   <= gap_cnt_nx;
            to_cnt    <= to_cnt_nx;
            score     <= score_nx;
            lives     <= lives_nx;
            level     <= level_nx;
            drop_addr <= addr_nx;
            drop_data <= data_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        to_cnt_nx  = to_cnt;
        score_nx   = score;
        lives_nx   = lives;
        level_nx   = level;
        addr_nx    = drop_addr;
        data_nx    = drop_data;
        done       = 1'b0;
        hit        = 1'b0;

        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_nx   = '0;
                    level_nx   = '0;
                    lives_nx   = LIVES;
                    gap_cnt_nx = gap_for(3'd0);
                    state_nx   = ST_GAP;
                end
            end

            ST_GAP: begin
                // Leaving on the count of 1 makes LAUNCH the (N+1)th cycle,
                // i.e. drop_go exactly N unpaused cycles after GAP entry.
                // Position and colour are latched on the entry edge so they
                // are already stable while drop_go is high.
                if (!pause) begin
                    if (gap_cnt <= 16'd1) begin
                        gap_cnt_nx = '0;
                        addr_nx    = {lfsr_q[2:0], 3'b000};
                        data_nx    = 8'h01 << lfsr_q[5:3];
                        state_nx   = ST_LAUNCH;
                    end else begin
                        gap_cnt_nx = gap_cnt - 16'd1;
                    end
                end
            end

            ST_LAUNCH: begin
                to_cnt_nx = TIMEOUT;
                state_nx  = ST_FALL;
            end

            ST_FALL: begin
                // A real result beats a coinciding timeout, and a result
                // cycle is never frozen by pause.
                if (res_valid) begin
                    done = 1'b1;
                    hit  = res_hit;
                end else if (!pause) begin
                    if (to_cnt <= 16'd1) begin
                        done      = 1'b1;
                        to_cnt_nx = '0;
                    end else begin
                        to_cnt_nx = to_cnt - 16'd1;
                    end
                end

                if (done) begin
                    if (hit) begin
                        if (score != 8'hFF) begin
                            score_nx = score + 8'd1;
                        end
                        level_nx   = level_of(score_nx);
                        // Gap follows the level that takes effect on this edge.
                        gap_cnt_nx = gap_for(level_nx);
                        state_nx   = ST_GAP;
                    end else if (lives <= 2'd1) begin
                        lives_nx = '0;
                        state_nx = ST_OVER;
                    end else begin
                        lives_nx   = lives - 2'd1;
                        gap_cnt_nx = gap_for(level);
                        state_nx   = ST_GAP;
                    end
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    assign drop_go    = (state == ST_LAUNCH);
    assign busy       = (state == ST_LAUNCH) || (state == ST_FALL);
    assign game_over  = (state == ST_OVER);
    assign drop_speed = 6'd1;

endmodule

// File: tb/tb_object_spawner.sv
// tb/tb_object_spawner.sv - scoreboard bench for object_spawner
module tb_object_spawner;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_hit = 1'b0;
    logic       drop_go;
    logic [5:0] drop_addr;
    logic [7:0] drop_data;
    logic [5:0] drop_speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] level;
    logic       game_over;
    logic       busy;

    always #5 clock = ~clock;

    object_spawner #(
        .GAP_BASE   (16'd10),
        .GAP_STEP   (16'd2),
        .GAP_MIN    (16'd4),
        .LEVEL_STEP (8'd2),
        .LIVES      (2'd3),
        .TIMEOUT    (16'd20),
        .SEED       (8'hA5)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .pause      (pause),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .drop_go    (drop_go),
        .drop_addr  (drop_addr),
        .drop_data  (drop_data),
        .drop_speed (drop_speed),
        .score      (score),
        .lives      (lives),
        .level      (level),
        .game_over  (game_over),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference LFSR (taps 8,6,5,4); m_prev is the value visible during the
    // cycle before the most recent edge, i.e. the one latched into LAUNCH.
    logic [7:0] m_cur, m_prev;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_cur  <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_cur;
            m_cur  <= {m_cur[6:0], m_cur[7] ^ m_cur[5] ^ m_cur[4] ^ m_cur[3]};
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        int         exp_cyc;
        logic [5:0] exp_addr;
        logic [7:0] exp_data;
        forever begin
            @(negedge clock);
            if (drop_go) begin
                chk("go_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_cyc  = exp_q.pop_front();
                    exp_addr = {m_prev[2:0], 3'b000};
                    exp_data = 8'h01 << m_prev[5:3];
                    chk("go_cycle", cyc, exp_cyc);
                    chk("go_addr", int'(drop_addr), int'(exp_addr));
                    chk("go_data", int'(drop_data), int'(exp_data));
                    chk("go_busy", int'(busy), 1);
                end
            end
        end
    endtask

    task automatic start_game(output int k);
        @(negedge clock);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_go(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (drop_go) begin
                at = cyc;
                break;
            end
        end
        chk("go_seen", int'(at >= 0), 1);
    endtask

    task automatic give_result(input logic h, output int g);
        @(negedge clock);
        chk("busy_fall", int'(busy), 1);
        res_valid = 1'b1;
        res_hit   = h;
        g = cyc + 1;
        @(negedge clock);
        res_valid = 1'b0;
        res_hit   = 1'b0;
    endtask

    initial begin
        int k, g, at;
        int hit_gap[6] = '{10, 8, 8, 6, 6, 4};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_go", int'(drop_go), 0);
        chk("rst_addr", int'(drop_addr), 0);
        chk("rst_data", int'(drop_data), 1);
        chk("rst_speed", int'(drop_speed), 1);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_level", int'(level), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_busy", int'(busy), 0);
        resetn = 1'b1;

        // First launch 10 cycles after start
        start_game(k);
        exp_q.push_back(k + 10);
        chk("gap_busy", int'(busy), 0);

        // Six hits: level rises every 2 points, gap shrinks and clamps at 4
        for (int i = 0; i < 6; i++) begin
            wait_go(at);
            give_result(1'b1, g);
            exp_q.push_back(g + hit_gap[i]);
            chk("hit_score", int'(score), i + 1);
            chk("hit_level", int'(level), (i + 1) / 2);
        end

        // Three misses to game over
        for (int i = 0; i < 3; i++) begin
            wait_go(at);
            give_result(1'b0, g);
            chk("miss_lives", int'(lives), 2 - i);
            chk("miss_score", int'(score), 6);
            if (i < 2) exp_q.push_back(g + 4);
        end
        chk("over_flag", int'(game_over), 1);
        chk("over_busy", int'(busy), 0);
        repeat (100) @(negedge clock);
        chk("over_still", int'(game_over), 1);
        chk("over_pending", exp_q.size(), 0);

        // Restart from OVER
        start_game(k);
        exp_q.push_back(k + 10);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        chk("restart_level", int'(level), 0);
        chk("restart_over", int'(game_over), 0);

        // Timeout after 20 FALL cycles counts as one miss
        wait_go(at);
        repeat (20) @(negedge clock);
        chk("to_lives_before", int'(lives), 3);
        @(negedge clock);
        chk("to_lives_after", int'(lives), 2);
        chk("to_busy_after", int'(busy), 0);
        exp_q.push_back(at + 31);

        // Hit on the expiry cycle wins over the timeout
        wait_go(at);
        repeat (20) @(negedge clock);
        res_valid = 1'b1;
        res_hit   = 1'b1;
        exp_q.push_back(cyc + 1 + 10);
        @(negedge clock);
        res_valid = 1'b0;
        res_hit   = 1'b0;
        chk("expiry_hit_score", int'(score), 1);
        chk("expiry_hit_lives", int'(lives), 2);

        // Pause 5 cycles in GAP; stray results in GAP are ignored
        wait_go(at);
        give_result(1'b0, g);
        chk("pause_lives", int'(lives), 1);
        exp_q.push_back(g + 15);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_valid = (i == 1) || (i == 3);
            res_hit   = (i == 1);
            @(negedge clock);
        end
        pause     = 1'b0;
        res_valid = 1'b0;
        res_hit   = 1'b0;
        repeat (2) @(negedge clock);
        res_valid = 1'b1;
        @(negedge clock);
        res_valid = 1'b0;
        chk("gap_res_score", int'(score), 1);
        chk("gap_res_lives", int'(lives), 1);

        // Asynchronous reset in the middle of FALL
        wait_go(at);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_go", int'(drop_go), 0);
        chk("arst_addr", int'(drop_addr), 0);
        chk("arst_data", int'(drop_data), 1);
        chk("arst_score", int'(score), 0);
        chk("arst_lives", int'(lives), 3);
        chk("arst_level", int'(level), 0);
        chk("arst_over", int'(game_over), 0);
        chk("arst_busy", int'(busy), 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (50) @(negedge clock);
        chk("post_rst_busy", int'(busy), 0);
        chk("final_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
